seq_detector_param: RTL and testbench

- Parametrised Mealy serial-pattern detector; next generation of the fixed 4-bit "1101" detectors.
- Pattern length is a parameter; pattern value and overlap/non-overlap mode are programmed at run time.
- Input is a qualified serial bitstream (one bit per valid cycle, first bit = pattern MSB).
- Sits between a serial front end and control logic; produces a same-cycle match pulse and a match count.

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/seq_det_if.sv | 28 ++
 rtl/seq_det_sat_counter.sv | 28 ++
 rtl/seq_detector_param.sv | 77 +++++++
 tb/tb_seq_detector_param.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, constants and helpers for seq_detector_param.
// Revision 1.0
`default_nettype none

package seq_det_pkg;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } ovl_mode_e;

  localparam int DEF_PAT_LEN = 4;

  function automatic int fill_w(input int pat_len);
    return $clog2(pat_len);
  endfunction

  localparam int FILL_W = fill_w(DEF_PAT_LEN);

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_if.sv
// seq_det_if: configuration, serial input and match outputs of seq_detector_param.
// Revision 1.0
`default_nettype none

interface seq_det_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output cfg_load, cfg_pattern, cfg_overlap, in_valid, in,
    input  out, match_cnt
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_overlap, in_valid, in,
    output out, match_cnt
  );
endinterface

`default_nettype wire

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: WIDTH-bit counter that saturates at all-ones.
// Revision 1.0
`default_nettype none

module seq_det_sat_counter
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_next;

  assign count_next = WIDTH'(sat_inc(32'(count), WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count_next;
    end
  end
endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy serial-pattern detector, run-time pattern and overlap mode.
// Match counter built only when SEQ_DET_MATCH_COUNT_EN is defined. Revision 1.0
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_det_if.slave bus
);
  localparam int               FILL_BITS = fill_w(PAT_LEN);
  localparam logic [FILL_BITS-1:0] FILL_MAX = FILL_BITS'(PAT_LEN - 1);

  logic [PAT_LEN-1:0]   pat_q;
  ovl_mode_e            ovl_q;
  logic [PAT_LEN-2:0]   hist;
  logic [PAT_LEN-2:0]   hist_shift;
  logic [FILL_BITS-1:0] fill;
  logic                 armed;
  logic                 hit;

  generate
    if (PAT_LEN > 2) begin : g_hist_wide
      assign hist_shift = {hist[PAT_LEN-3:0], bus.in};
    end else begin : g_hist_bit
      assign hist_shift = bus.in;
    end
  endgenerate

  assign armed = (fill == FILL_MAX);
  // Gated by rst so the pulse drops the instant reset asserts.
  assign hit   = rst & bus.in_valid & ~bus.cfg_load & armed & ({hist, bus.in} == pat_q);
  assign bus.out = hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      ovl_q <= MODE_NONOVL;
      hist  <= '0;
      fill  <= '0;
    end else if (bus.cfg_load) begin
      pat_q <= bus.cfg_pattern;
      ovl_q <= ovl_mode_e'(bus.cfg_overlap);
      hist  <= '0;
      fill  <= '0;
    end else if (bus.in_valid) begin
      if (hit && ovl_q == MODE_NONOVL) begin
        hist <= '0;
        fill <= '0;
      end else begin
        // Overlap matches keep fill at FILL_MAX so matched bits seed the next one.
        hist <= hist_shift;
        fill <= armed ? fill : fill + FILL_BITS'(1);
      end
    end
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  seq_det_sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .count (bus.match_cnt)
  );
`else
  assign bus.match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench; dut_a CNT_W=8, dut_b CNT_W=2, shared stimulus.
// Expected match_cnt honours SEQ_DET_MATCH_COUNT_EN. Revision 1.0
`default_nettype none

module tb_seq_detector_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in_bit;

  int n_cmp = 0;
  int n_err = 0;
  int exp_a = 0;
  int exp_b = 0;

  seq_det_if #(.PAT_LEN(4), .CNT_W(8)) ba ();
  seq_det_if #(.PAT_LEN(4), .CNT_W(2)) bb ();

  assign ba.cfg_load    = cfg_load;
  assign ba.cfg_pattern = cfg_pattern;
  assign ba.cfg_overlap = cfg_overlap;
  assign ba.in_valid    = in_valid;
  assign ba.in          = in_bit;
  assign bb.cfg_load    = cfg_load;
  assign bb.cfg_pattern = cfg_pattern;
  assign bb.cfg_overlap = cfg_overlap;
  assign bb.in_valid    = in_valid;
  assign bb.in          = in_bit;

  seq_detector_param #(.PAT_LEN(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  seq_detector_param #(.PAT_LEN(4), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef SEQ_DET_MATCH_COUNT_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic exp_out, input string tag);
    cfg_load = 1'b0;
    in_valid = v;
    in_bit   = b;
    @(negedge clk);
    check({tag, ".out_a"}, 32'(ba.out), 32'(exp_out));
    check({tag, ".out_b"}, 32'(bb.out), 32'(exp_out));
    @(posedge clk);
    #1;
    if (exp_out) begin
      if (exp_a < 255) exp_a++;
      if (exp_b < 3)   exp_b++;
    end
    check({tag, ".cnt_a"}, 32'(ba.match_cnt), cnt_exp(exp_a));
    check({tag, ".cnt_b"}, 32'(bb.match_cnt), cnt_exp(exp_b));
  endtask

  task automatic load_cfg(input logic [3:0] pat, input logic ovl, input logic b, input string tag);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    in_bit      = b;
    @(negedge clk);
    check({tag, ".load_out"}, 32'(ba.out), 32'd0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  // Vectors are written first-bit-first (MSB = first cycle).
  task automatic run_stream(input logic [15:0] bits, input logic [15:0] valids,
                            input logic [15:0] exps, input int n, input string name);
    for (int i = n - 1; i >= 0; i--) begin
      step(valids[i], bits[i], exps[i], $sformatf("%s[%0d]", name, n - 1 - i));
    end
  endtask

  initial begin
    rst         = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_overlap = 1'b0;
    in_valid    = 1'b1;
    in_bit      = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i[0], 1'b0, $sformatf("reset[%0d]", i));
    end
    rst = 1'b1;

    // Reset pattern is 0000: a match needs four fresh zeros after release.
    run_stream(16'b0000, 16'b1111, 16'b0001, 4, "post_rst");

    load_cfg(4'b1101, 1'b0, 1'b1, "nonovl");
    run_stream(16'b1101101, 16'h7F, 16'b0001000, 7, "nonovl");

    load_cfg(4'b1101, 1'b1, 1'b0, "ovl");
    run_stream(16'b1101101, 16'h7F, 16'b0001001, 7, "ovl");

    // Gaps while armed carry in=1, which would complete 1101 if not qualified.
    load_cfg(4'b1101, 1'b1, 1'b0, "gap");
    run_stream(16'b1101111, 16'b1110001, 16'b0000001, 7, "gap");

    run_stream(16'b110, 16'b111, 16'b000, 3, "preload");
    load_cfg(4'b0110, 1'b0, 1'b1, "reload");
    run_stream(16'b0110, 16'b1111, 16'b0001, 4, "reload");

    load_cfg(4'b1101, 1'b1, 1'b0, "midrst");
    run_stream(16'b110, 16'b111, 16'b000, 3, "midrst");
    in_valid = 1'b1;
    in_bit   = 1'b1;
    #2;
    check("midrst.pre_out", 32'(ba.out), 32'd1);
    rst = 1'b0;
    #1;
    exp_a = 0;
    exp_b = 0;
    check("midrst.out", 32'(ba.out), 32'd0);
    check("midrst.cnt_a", 32'(ba.match_cnt), 32'd0);
    check("midrst.cnt_b", 32'(bb.match_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    load_cfg(4'b1111, 1'b1, 1'b0, "sat");
    run_stream(16'b11111111, 16'hFF, 16'b00011111, 8, "sat");
    check("sat.final_a", 32'(ba.match_cnt), cnt_exp(5));
    check("sat.final_b", 32'(bb.match_cnt), cnt_exp(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
